stream_decipher: RTL and testbench
==================================

STREAM_DECIPHER -- requirements
Module: stream_decipher

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  ciphertext byte offered.
REQ-005 in_data  input  8  ciphertext byte.
REQ-006 in_last  input  1  offered byte ends the current message.
REQ-007 in_ready  output  1  block accepts the offered byte this cycle.
REQ-008 out_valid  output  1  plaintext byte available.
REQ-009 out_data  output  8  plaintext byte.
REQ-010 out_last  output  1  out_data is the final byte of a message.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 clear  input  1  synchronous flush of all buffered and chain state.
REQ-013 count  output  4  number of bytes buffered, 0..8.
REQ-014 busy  output  1  high while a message is in progress (state ACTIVE).

Function
REQ-015 A transfer SHALL occur on a rising clk edge when valid and ready are both high; it SHALL NOT occur otherwise.
REQ-016 The chain register SHALL be 8 bits, initial value 8'h00.
REQ-017 On input accept: plaintext = in_data XOR chain; push {in_last, plaintext}; chain <= in_data, or 8'h00 when in_last=1.
REQ-018 Plaintext buffering SHALL use a FIFO 9 bits wide and 8 entries deep; order SHALL be preserved.
REQ-019 in_ready SHALL be equal to (count < 8) and SHALL be low while clear=1.
REQ-020 out_valid SHALL be equal to (count > 0); out_data and out_last SHALL show the FIFO head.
REQ-021 Latency: a byte accepted at edge N SHALL appear on out_valid after edge N when the FIFO was empty.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-023 When full, a pop at an edge SHALL NOT allow a push at that same edge; in_ready rises the following cycle.
REQ-024 FIFO pointers SHALL be 3 bits and SHALL wrap 7->0 without loss.
REQ-025 The state machine SHALL have states IDLE and ACTIVE.
REQ-026 IDLE->ACTIVE on accept with in_last=0; ACTIVE->IDLE on accept with in_last=1; IDLE->IDLE on accept with in_last=1 (single-byte message).
REQ-027 clear=1 SHALL empty the FIFO, set chain to 8'h00, and set the state to IDLE; it SHALL take priority over push and pop at the same edge.
REQ-028 out_valid SHALL be held stable with unchanged data until out_ready=1.

Reset
REQ-029 While rst_n=0: FIFO empty, count=0, chain=8'h00, state IDLE.
REQ-030 While rst_n=0, outputs SHALL be: out_valid=0, out_data=8'h00, out_last=0, in_ready=0, busy=0.
REQ-031 in_ready SHALL go high on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-message SHALL discard all buffered bytes and the chain value.

Structure
REQ-033 Package stream_cipher_pkg SHALL hold: BYTE_W=8, FIFO_DEPTH=8, CHAIN_INIT=8'h00, and the state enum {IDLE, ACTIVE}.
REQ-034 One sub-module, byte_fifo (parameterised width/depth sync FIFO, clk/rst_n/clear), SHALL hold the storage; chain and FSM SHALL live in stream_decipher.

Verification
REQ-035 Decode scenario: feed 0x41, 0x03, 0x40 with last on the third byte -> out 0x41, 0x42, 0x43, with out_last only on 0x43.
REQ-036 Back-to-back messages: feed 0x41 (last) then 0x41 (last) -> out 0x41, 0x41, confirming the chain resets to 0 between messages.
REQ-037 Backpressure: hold out_ready=0 and offer 10 bytes -> 8 accepted, count=8, in_ready=0.
REQ-038 Drain after REQ-037: raise out_ready -> 8 bytes emitted in order, with pointers wrapping.
REQ-039 Concurrent push and pop at count=3 for 20 cycles -> count stays 3 and the data stream matches the model.
REQ-040 Clear at count=5 in ACTIVE -> next edge count=0, busy=0; then feeding 0x41 -> out 0x41.
REQ-041 Async reset mid-message at count=4 -> outputs at reset values immediately; after reset, feeding 0x41 -> out 0x41.

Source files
------------

// File: rtl/stream_cipher_pkg.sv
// ---------------------------------------------------------------------------
// stream_cipher_pkg : shared widths, chain seed and FSM states for decipher
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stream_cipher_pkg;

  localparam int BYTE_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int ENTRY_W    = BYTE_W + 1;
  localparam int COUNT_W    = $clog2(FIFO_DEPTH + 1);

  localparam logic [BYTE_W-1:0] CHAIN_INIT = 8'h00;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic [BYTE_W-1:0] unchain(input logic [BYTE_W-1:0] cipher,
                                                input logic [BYTE_W-1:0] chain);
    return cipher ^ chain;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_decipher_if.sv
// ---------------------------------------------------------------------------
// stream_decipher_if : ciphertext in / plaintext out streams plus status
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface stream_decipher_if;
  import stream_cipher_pkg::*;

  logic               in_valid;
  logic [BYTE_W-1:0]  in_data;
  logic               in_last;
  logic               in_ready;
  logic               out_valid;
  logic [BYTE_W-1:0]  out_data;
  logic               out_last;
  logic               out_ready;
  logic               clear;
  logic [COUNT_W-1:0] count;
  logic               busy;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, clear,
    output in_ready, out_valid, out_data, out_last, count, busy
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, clear,
    input  in_ready, out_valid, out_data, out_last, count, busy
  );

endinterface

`default_nettype wire

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo : parameterised synchronous FIFO with wrapping pointers and flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt;
  // Zero the head while empty so the output bus reads 0 out of reset
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/stream_decipher.sv
// ---------------------------------------------------------------------------
// stream_decipher : chained-XOR byte decipher feeding an 8-deep output FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stream_decipher
  import stream_cipher_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  stream_decipher_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic [BYTE_W-1:0]  chain;
  logic [BYTE_W-1:0]  chain_nxt;
  logic               ready_en;
  logic               accept;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;

  // Low throughout reset; rises on the first edge after rst_n is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign bus.in_ready  = ready_en && !fifo_full && !bus.clear;
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head[BYTE_W-1:0];
  assign bus.out_last  = fifo_head[BYTE_W];
  assign bus.busy      = (state == ACTIVE);

  byte_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.clear),
    .push      (accept),
    .push_data ({bus.in_last, unchain(bus.in_data, chain)}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (bus.count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      chain <= CHAIN_INIT;
    end else begin
      state <= state_nxt;
      chain <= chain_nxt;
    end
  end

  // The chain reseeds at every message boundary so each message decodes alone
  always_comb begin
    state_nxt = state;
    chain_nxt = chain;
    if (bus.clear) begin
      state_nxt = IDLE;
      chain_nxt = CHAIN_INIT;
    end else if (accept) begin
      chain_nxt = bus.in_last ? CHAIN_INIT : bus.in_data;
      unique case (state)
        IDLE:    state_nxt = bus.in_last ? IDLE : ACTIVE;
        ACTIVE:  state_nxt = bus.in_last ? IDLE : ACTIVE;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_decipher.sv
// ---------------------------------------------------------------------------
// tb_stream_decipher : directed and random stimulus against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stream_decipher;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stream_decipher_if sif ();

  stream_decipher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] q   [$];
  logic [8:0] got [$];
  logic [7:0] prev   = 8'h00;
  bit         armed  = 1'b0;
  bit         busy_m = 1'b0;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    prev   = 8'h00;
    busy_m = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic cycle(output bit acc);
    bit         exp_ready, pp, lst;
    logic [7:0] dat;
    #1;
    exp_ready = armed && !sif.clear && (q.size() < 8);
    chk("in_ready",  sif.in_ready,  exp_ready);
    chk("out_valid", sif.out_valid, q.size() > 0);
    chk("count",     sif.count,     q.size());
    chk("busy",      sif.busy,      busy_m);
    if (q.size() > 0) chk("head", {sif.out_last, sif.out_data}, q[0]);
    acc = sif.in_valid && exp_ready;
    pp  = (q.size() > 0) && sif.out_ready;
    dat = sif.in_data;
    lst = sif.in_last;
    @(posedge clk);
    if (rst_n) begin
      armed = 1'b1;
      if (sif.clear) begin
        model_reset();
      end else begin
        if (pp) got.push_back(q.pop_front());
        if (acc) begin
          q.push_back({lst, dat ^ prev});
          prev   = lst ? 8'h00 : dat;
          busy_m = !lst;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    bit acc = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    sif.in_last  = last;
    for (int i = 0; i < 50 && !acc; i++) cycle(acc);
    chk("send_accepted", acc, 1'b1);
    sif.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) cycle(acc);
    chk("drain_empty", q.size() == 0, 1'b1);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_out_valid"}, sif.out_valid, 1'b0);
    chk({tag, "_out_data"},  sif.out_data,  8'h00);
    chk({tag, "_out_last"},  sif.out_last,  1'b0);
    chk({tag, "_in_ready"},  sif.in_ready,  1'b0);
    chk({tag, "_busy"},      sif.busy,      1'b0);
    chk({tag, "_count"},     sif.count,     4'd0);
  endtask

  initial begin
    bit acc;
    int n;
    sif.in_valid  = 1'b0;
    sif.in_data   = 8'h00;
    sif.in_last   = 1'b0;
    sif.out_ready = 1'b0;
    sif.clear     = 1'b0;

    @(negedge clk); #1;
    reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(acc);
    cycle(acc);

    // Three-byte message decodes to "ABC"
    got.delete();
    sif.out_ready = 1'b1;
    send(8'h41, 1'b0);
    send(8'h03, 1'b0);
    send(8'h40, 1'b1);
    drain();
    chk("abc_len", got.size(), 3);
    if (got.size() == 3) begin
      chk("abc_0", got[0], 9'h041);
      chk("abc_1", got[1], 9'h042);
      chk("abc_2", got[2], 9'h143);
    end

    // Back-to-back single-byte messages
    got.delete();
    send(8'h41, 1'b1);
    send(8'h41, 1'b1);
    drain();
    chk("b2b_len", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_0", got[0], 9'h141);
      chk("b2b_1", got[1], 9'h141);
    end

    // Backpressure: 10 offers, only 8 fit
    sif.out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data  = 8'($urandom);
      sif.in_last  = 1'b0;
      cycle(acc);
      n += int'(acc);
    end
    sif.in_valid = 1'b0;
    #1;
    chk("bp_accepted", n, 8);
    chk("bp_count",    sif.count,    4'd8);
    chk("bp_in_ready", sif.in_ready, 1'b0);

    // Drain the full FIFO across the pointer wrap
    got.delete();
    drain();
    chk("bp_drain_len", got.size(), 8);

    // Steady push+pop at depth 3
    sif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    sif.out_ready = 1'b1;
    sif.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sif.in_data = 8'($urandom);
      sif.in_last = ($urandom_range(0, 3) == 0);
      cycle(acc);
      chk("conc_count", sif.count, 4'd3);
    end
    drain();

    // Clear mid-message with traffic offered on both sides
    sif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0);
    chk("pre_clear_busy",  sif.busy,  1'b1);
    chk("pre_clear_count", sif.count, 4'd5);
    sif.clear     = 1'b1;
    sif.in_valid  = 1'b1;
    sif.in_data   = 8'h5a;
    sif.out_ready = 1'b1;
    cycle(acc);
    sif.clear     = 1'b0;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b0;
    chk("clear_count", sif.count, 4'd0);
    chk("clear_busy",  sif.busy,  1'b0);
    got.delete();
    sif.out_ready = 1'b1;
    send(8'h41, 1'b1);
    drain();
    chk("clear_len", got.size(), 1);
    if (got.size() == 1) chk("clear_byte", got[0], 9'h141);

    // Asynchronous reset in the middle of a message
    sif.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
    chk("pre_rst_count", sif.count, 4'd4);
    #2 rst_n = 1'b0;
    #1;
    reset_outputs("arst");
    model_reset();
    armed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(acc);
    got.delete();
    sif.out_ready = 1'b1;
    send(8'h41, 1'b1);
    drain();
    chk("arst_len", got.size(), 1);
    if (got.size() == 1) chk("arst_byte", got[0], 9'h141);

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      sif.in_valid  = 1'($urandom_range(0, 1));
      sif.in_data   = 8'($urandom);
      sif.in_last   = ($urandom_range(0, 4) == 0);
      sif.out_ready = 1'($urandom_range(0, 1));
      sif.clear     = ($urandom_range(0, 29) == 0);
      cycle(acc);
    end
    sif.clear = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
